neur_in_unit: RTL and testbench

- Input-side counterpart of the neural output unit. Accepts 32-bit words from the core datapath (one lane, or two compressed 16-bit lanes per word) and assembles an N_LANES x LANE_W operand vector.
- Hands the full vector to the neural compute array over a valid/ready handshake.
- Lane packing matches the output unit: lane k sits at bits [(N_LANES-1-k)*LANE_W +: LANE_W]. A compressed word carries its upper half into the lower-numbered lane.

---
 rtl/neur_pkg.sv | 8 +
 rtl/neur_half_ext.sv | 10 +
 rtl/neur_in_unit.sv | 84 ++++++++
 tb/tb_neur_in_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neur_pkg.sv
// neur_pkg: shared lane geometry, option bit indices and FSM states for the neural I/O units.
package neur_pkg;
   localparam int N_LANES    = 4;
   localparam int LANE_W     = 32;
   localparam int OPT_SIGNED = 1;
   localparam int OPT_DECOMP = 0;
   typedef enum logic {FILL, FULL} state_t;
endpackage

// File: rtl/neur_half_ext.sv
// neur_half_ext: widens a 16-bit half-word to LANE_W bits, signed or zero extended.
module neur_half_ext #(
   parameter int LANE_W = 32
) (
   input  logic [15:0]       i_half,
   input  logic              i_signed,
   output logic [LANE_W-1:0] o_word
);
   assign o_word = {{(LANE_W-16){i_signed & i_half[15]}}, i_half};
endmodule

// File: rtl/neur_in_unit.sv
// neur_in_unit: assembles 32-bit (optionally two-lane compressed) input words into an
// N_LANES x LANE_W operand vector and hands it over a valid/ready handshake.
module neur_in_unit #(
   parameter int N_LANES = neur_pkg::N_LANES,
   parameter int LANE_W  = neur_pkg::LANE_W
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [31:0]                 in_data_i,
   input  logic [1:0]                  in_options_i,
   input  logic                        flush_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [N_LANES*LANE_W-1:0]   out_operands_o,
   output logic [$clog2(N_LANES):0]    out_count_o
);
   import neur_pkg::*;
   localparam int PW = $clog2(N_LANES) + 1;
   state_t            r_state;
   logic [LANE_W-1:0] r_lane [N_LANES];
   logic [LANE_W-1:0] r_spill;
   logic              r_spill_v;
   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     r_count;
   logic [LANE_W-1:0] w_hi;
   logic [LANE_W-1:0] w_lo;
   logic              w_xfer;
   logic              w_decomp;
   logic              w_last;
   logic [PW-1:0]     w_ptr_nxt;
   logic              w_go_full;
   assign in_ready_o  = (r_state == FILL);
   assign out_valid_o = (r_state == FULL);
   assign out_count_o = r_count;
   assign w_xfer      = in_valid_i & in_ready_o;
   assign w_decomp    = in_options_i[OPT_DECOMP];
   assign w_last      = (r_ptr == PW'(N_LANES - 1));
   // A compressed word at the last lane saturates the pointer; its lower half spills.
   assign w_ptr_nxt   = !w_xfer ? r_ptr :
                        (w_decomp && w_last) ? PW'(N_LANES) :
                        r_ptr + (w_decomp ? PW'(2) : PW'(1));
   assign w_go_full   = (w_ptr_nxt == PW'(N_LANES)) || (flush_i && w_ptr_nxt != '0);
   neur_half_ext #(.LANE_W(LANE_W)) u_ext_hi (
      .i_half(in_data_i[31:16]), .i_signed(in_options_i[OPT_SIGNED]), .o_word(w_hi)
   );
   neur_half_ext #(.LANE_W(LANE_W)) u_ext_lo (
      .i_half(in_data_i[15:0]), .i_signed(in_options_i[OPT_SIGNED]), .o_word(w_lo)
   );
   for (genvar g = 0; g < N_LANES; g++) begin : g_pack
      assign out_operands_o[(N_LANES-1-g)*LANE_W +: LANE_W] = r_lane[g];
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= FILL;
         r_ptr     <= '0;
         r_count   <= '0;
         r_spill   <= '0;
         r_spill_v <= 1'b0;
         for (int k = 0; k < N_LANES; k++) r_lane[k] <= '0;
      end else if (r_state == FILL) begin
         for (int k = 0; k < N_LANES; k++) begin
            if (w_xfer && r_ptr == PW'(k)) r_lane[k] <= w_decomp ? w_hi : in_data_i;
            if (w_xfer && w_decomp && r_ptr + PW'(1) == PW'(k)) r_lane[k] <= w_lo;
         end
         r_ptr <= w_ptr_nxt;
         if (w_xfer && w_decomp && w_last) begin
            r_spill   <= w_lo;
            r_spill_v <= 1'b1;
         end
         if (w_go_full) begin
            r_state <= FULL;
            r_count <= w_ptr_nxt;
         end
      end else if (out_ready_i) begin
         r_state   <= FILL;
         r_count   <= '0;
         r_ptr     <= PW'(r_spill_v);
         r_spill_v <= 1'b0;
         for (int k = 0; k < N_LANES; k++) r_lane[k] <= (k == 0 && r_spill_v) ? r_spill : '0;
      end
   end
endmodule

// File: tb/tb_neur_in_unit.sv
// tb_neur_in_unit: directed scenario tests for neur_in_unit with hand-computed vectors.
module tb_neur_in_unit;
   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         in_valid_i = 1'b0;
   logic         in_ready_o;
   logic [31:0]  in_data_i = '0;
   logic [1:0]   in_options_i = '0;
   logic         flush_i = 1'b0;
   logic         out_valid_o;
   logic         out_ready_i = 1'b0;
   logic [127:0] out_operands_o;
   logic [2:0]   out_count_o;
   int checks = 0;
   int errors = 0;
   neur_in_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_data_i(in_data_i), .in_options_i(in_options_i), .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_operands_o(out_operands_o), .out_count_o(out_count_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic send(input logic [31:0] d, input logic [1:0] opt);
      int n = 0;
      in_valid_i = 1'b1;
      in_data_i = d;
      in_options_i = opt;
      while (!in_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (n == 50) begin
         errors++;
         $display("FAIL send_timeout: in_ready_o=%b required 1 within 50 cycles", in_ready_o);
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
   endtask
   task automatic handshake();
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0;
   endtask
   task automatic pulse_flush();
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
   endtask
   task automatic test_reset();
      rst_i = 1'b1;
      #3;
      checks++;
      if ({in_ready_o, out_valid_o, out_count_o, out_operands_o} !== {1'b1, 1'b0, 3'd0, 128'h0}) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b cnt=%0d ops=%h required 1 0 0 0", in_ready_o, out_valid_o, out_count_o, out_operands_o);
      end
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({in_ready_o, out_valid_o} !== 2'b10) begin
         errors++;
         $display("FAIL post_reset: rdy=%b vld=%b required 1 0", in_ready_o, out_valid_o);
      end
   endtask
   task automatic test_uncompressed();
      out_ready_i = 1'b1;
      send(32'h11111111, 2'b00);
      send(32'h22222222, 2'b00);
      send(32'h33333333, 2'b00);
      checks++;
      if (out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL early_valid: out_valid_o=%b required 0", out_valid_o);
      end
      send(32'h44444444, 2'b00);
      checks++;
      if ({out_valid_o, in_ready_o, out_count_o, out_operands_o} !==
          {1'b1, 1'b0, 3'd4, 128'h11111111_22222222_33333333_44444444}) begin
         errors++;
         $display("FAIL uncompressed: vld=%b rdy=%b cnt=%0d ops=%h required 1 0 4 11111111222222223333333344444444", out_valid_o, in_ready_o, out_count_o, out_operands_o);
      end
      @(negedge clk_i);
      checks++;
      if ({out_valid_o, in_ready_o, out_operands_o} !== {1'b0, 1'b1, 128'h0}) begin
         errors++;
         $display("FAIL after_handshake: vld=%b rdy=%b ops=%h required 0 1 0", out_valid_o, in_ready_o, out_operands_o);
      end
      out_ready_i = 1'b0;
   endtask
   task automatic test_compressed();
      out_ready_i = 1'b1;
      send(32'hFFFF0002, 2'b11);
      send(32'h80007FFF, 2'b11);
      checks++;
      if ({out_valid_o, out_count_o, out_operands_o} !== {1'b1, 3'd4, 128'hFFFFFFFF_00000002_FFFF8000_00007FFF}) begin
         errors++;
         $display("FAIL comp_signed: vld=%b cnt=%0d ops=%h required 1 4 FFFFFFFF00000002FFFF800000007FFF", out_valid_o, out_count_o, out_operands_o);
      end
      @(negedge clk_i);
      send(32'hFFFF0002, 2'b01);
      send(32'h80007FFF, 2'b01);
      checks++;
      if ({out_valid_o, out_count_o, out_operands_o} !== {1'b1, 3'd4, 128'h0000FFFF_00000002_00008000_00007FFF}) begin
         errors++;
         $display("FAIL comp_unsigned: vld=%b cnt=%0d ops=%h required 1 4 0000FFFF000000020000800000007FFF", out_valid_o, out_count_o, out_operands_o);
      end
      @(negedge clk_i);
      out_ready_i = 1'b0;
   endtask
   task automatic test_spill();
      send(32'h0000000A, 2'b00);
      send(32'h00010002, 2'b01);
      send(32'h00030004, 2'b01);
      checks++;
      if ({out_valid_o, out_count_o, out_operands_o} !== {1'b1, 3'd4, 128'h0000000A_00000001_00000002_00000003}) begin
         errors++;
         $display("FAIL spill_vec1: vld=%b cnt=%0d ops=%h required 1 4 0000000A000000010000000200000003", out_valid_o, out_count_o, out_operands_o);
      end
      handshake();
      checks++;
      if ({out_valid_o, in_ready_o, out_count_o, out_operands_o} !== {1'b0, 1'b1, 3'd0, 128'h00000004_00000000_00000000_00000000}) begin
         errors++;
         $display("FAIL spill_lane0: vld=%b rdy=%b cnt=%0d ops=%h required 0 1 0 00000004000000000000000000000000", out_valid_o, in_ready_o, out_count_o, out_operands_o);
      end
      send(32'h5, 2'b00);
      send(32'h6, 2'b00);
      pulse_flush();
      checks++;
      if ({out_valid_o, out_count_o, out_operands_o} !== {1'b1, 3'd3, 128'h00000004_00000005_00000006_00000000}) begin
         errors++;
         $display("FAIL spill_vec2: vld=%b cnt=%0d ops=%h required 1 3 00000004000000050000000600000000", out_valid_o, out_count_o, out_operands_o);
      end
      handshake();
   endtask
   task automatic test_backpressure();
      logic [127:0] exp_v = 128'h00000001_00000002_00000003_00000004;
      send(32'h1, 2'b00);
      send(32'h2, 2'b00);
      send(32'h3, 2'b00);
      send(32'h4, 2'b00);
      in_valid_i = 1'b1;
      in_data_i = 32'h99;
      in_options_i = 2'b00;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({in_ready_o, out_valid_o, out_count_o, out_operands_o} !== {1'b0, 1'b1, 3'd4, exp_v}) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: rdy=%b vld=%b cnt=%0d ops=%h required 0 1 4 %h", i, in_ready_o, out_valid_o, out_count_o, out_operands_o, exp_v);
         end
         @(negedge clk_i);
      end
      handshake();
      checks++;
      if ({in_ready_o, out_operands_o} !== {1'b1, 128'h0}) begin
         errors++;
         $display("FAIL bp_no_accept: rdy=%b ops=%h required 1 0", in_ready_o, out_operands_o);
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
      checks++;
      if (out_operands_o !== 128'h00000099_00000000_00000000_00000000) begin
         errors++;
         $display("FAIL bp_accept_after: ops=%h required 00000099000000000000000000000000", out_operands_o);
      end
      pulse_flush();
      checks++;
      if ({out_valid_o, out_count_o} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL bp_flush: vld=%b cnt=%0d required 1 1", out_valid_o, out_count_o);
      end
      handshake();
   endtask
   task automatic test_flush();
      send(32'h1, 2'b00);
      send(32'h2, 2'b00);
      in_valid_i = 1'b1;
      in_data_i = 32'h7;
      in_options_i = 2'b00;
      flush_i = 1'b1;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      flush_i = 1'b0;
      checks++;
      if ({out_valid_o, out_count_o, out_operands_o} !== {1'b1, 3'd3, 128'h00000001_00000002_00000007_00000000}) begin
         errors++;
         $display("FAIL flush_with_word: vld=%b cnt=%0d ops=%h required 1 3 00000001000000020000000700000000", out_valid_o, out_count_o, out_operands_o);
      end
      handshake();
      pulse_flush();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({out_valid_o, in_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL flush_empty[%0d]: vld=%b rdy=%b required 0 1", i, out_valid_o, in_ready_o);
         end
         @(negedge clk_i);
      end
   endtask
   task automatic test_reset_full();
      send(32'h0000000A, 2'b00);
      send(32'h00010002, 2'b01);
      send(32'h00030004, 2'b01);
      checks++;
      if (out_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_setup: vld=%b required 1", out_valid_o);
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if ({out_valid_o, in_ready_o, out_count_o, out_operands_o} !== {1'b0, 1'b1, 3'd0, 128'h0}) begin
         errors++;
         $display("FAIL rst_in_full: vld=%b rdy=%b cnt=%0d ops=%h required 0 1 0 0", out_valid_o, in_ready_o, out_count_o, out_operands_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      send(32'h5, 2'b00);
      pulse_flush();
      checks++;
      if ({out_valid_o, out_count_o, out_operands_o} !== {1'b1, 3'd1, 128'h00000005_00000000_00000000_00000000}) begin
         errors++;
         $display("FAIL rst_no_spill: vld=%b cnt=%0d ops=%h required 1 1 00000005000000000000000000000000", out_valid_o, out_count_o, out_operands_o);
      end
      handshake();
   endtask
   initial begin
      test_reset();
      test_uncompressed();
      test_compressed();
      test_spill();
      test_backpressure();
      test_flush();
      test_reset_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
